sha256_stream_core: RTL and testbench

SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

---
 rtl/sha256_stream_core.sv | 175 +++++++++++++++++
 tb/tb_sha256_stream_core.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_core.sv
// rtl/sha256_stream_core.sv - block-streaming SHA-256/SHA-224 compression core
module sha256_stream_core #(
    parameter int RPC   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blk_valid,
    output logic             blk_ready,
    input  logic [511:0]     blk_data,
    input  logic             blk_first,
    input  logic             blk_last,
    input  logic             mode224,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [255:0]     digest,
    output logic [CNT_W-1:0] blk_count,
    output logic             proto_err
);
    generate
        if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
            $error("sha256_stream_core: RPC must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [5:0] LAST_RND = 6'(64 - RPC);
    localparam logic [5:0] RPC_STEP = 6'(RPC);

    localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {IDLE, ROUND, UPDATE, OUT} state_t;

    state_t         state_q, state_d;
    logic [255:0]   cv_q;      // chaining value H0..H7, H0 in the top word
    logic [255:0]   work_q;    // working registers a..h, a in the top word
    logic [255:0]   work_nxt;
    logic [511:0]   win_q;     // 16-word schedule window, oldest word on top
    logic [511:0]   win_nxt;
    logic [5:0]     rnd_q;
    logic           mode_q;
    logic           open_q;
    logic           last_q;
    logic           accept;
    logic           start_new;
    logic [255:0]   iv_sel;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] round_step(input logic [255:0] st, input logic [31:0] k,
                                                input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = st;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [511:0] sched_step(input logic [511:0] win);
        logic [31:0] w0, w1, w9, w14, nw;
        w0  = win[511:480];
        w1  = win[479:448];
        w9  = win[223:192];
        w14 = win[63:32];
        nw  = (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + w9
            + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w0;
        return {win[479:0], nw};
    endfunction

    assign accept    = blk_valid && blk_ready;
    assign start_new = blk_first || !open_q;
    assign iv_sel    = mode224 ? IV224 : IV256;
    assign digest    = {cv_q[255:32], mode_q ? 32'h0 : cv_q[31:0]};

    // RPC chained rounds, each consuming the window head and sliding the schedule
    always_comb begin
        work_nxt = work_q;
        win_nxt  = win_q;
        for (int i = 0; i < RPC; i++) begin
            work_nxt = round_step(work_nxt, K[rnd_q + 6'(i)], win_nxt[511:480]);
            win_nxt  = sched_step(win_nxt);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ROUND;
            ROUND:   if (rnd_q == LAST_RND) state_d = UPDATE;
            UPDATE:  state_d = last_q ? OUT : IDLE;
            OUT:     if (dig_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs decoded from state; ready held low while reset is applied
    always_comb begin
        blk_ready = (state_q == IDLE) && !reset;
        dig_valid = (state_q == OUT);
    end

    // datapath: block load, rounds, chaining update, message bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            cv_q      <= '0;
            work_q    <= '0;
            win_q     <= '0;
            rnd_q     <= '0;
            mode_q    <= 1'b0;
            open_q    <= 1'b0;
            last_q    <= 1'b0;
            blk_count <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        win_q     <= blk_data;
                        rnd_q     <= '0;
                        last_q    <= blk_last;
                        open_q    <= 1'b1;
                        // first-while-open and continuation-without-open are both violations
                        proto_err <= (blk_first == open_q);
                        if (start_new) begin
                            cv_q      <= iv_sel;
                            work_q    <= iv_sel;
                            mode_q    <= mode224;
                            blk_count <= CNT_W'(1);
                        end else begin
                            work_q <= cv_q;
                            if (blk_count != '1) blk_count <= blk_count + CNT_W'(1);
                        end
                    end
                end
                ROUND: begin
                    work_q <= work_nxt;
                    win_q  <= win_nxt;
                    rnd_q  <= rnd_q + RPC_STEP;
                end
                UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        cv_q[32*i +: 32] <= cv_q[32*i +: 32] + work_q[32*i +: 32];
                    end
                end
                OUT: begin
                    if (dig_ready) open_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_stream_core.sv
// tb/tb_sha256_stream_core.sv - randomized self-checking bench for sha256_stream_core
`timescale 1ns/1ps
module tb_sha256_stream_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         blk_valid [2];
    logic         blk_ready [2];
    logic [511:0] blk_data  [2];
    logic         blk_first [2];
    logic         blk_last  [2];
    logic         mode224   [2];
    logic         dig_valid [2];
    logic         dig_ready [2];
    logic [255:0] digest    [2];
    logic         proto_err [2];
    logic [15:0]  blk_count0;
    logic [1:0]   blk_count1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int perr [2] = '{0, 0};

    // unit 0: RPC=1, 16-bit counter; unit 1: RPC=4, 2-bit counter to reach saturation
    sha256_stream_core #(.RPC(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]),
        .blk_data(blk_data[0]), .blk_first(blk_first[0]), .blk_last(blk_last[0]),
        .mode224(mode224[0]), .dig_valid(dig_valid[0]), .dig_ready(dig_ready[0]),
        .digest(digest[0]), .blk_count(blk_count0), .proto_err(proto_err[0]));

    sha256_stream_core #(.RPC(4), .CNT_W(2)) u_dut4 (
        .clk(clk), .reset(reset), .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]),
        .blk_data(blk_data[1]), .blk_first(blk_first[1]), .blk_last(blk_last[1]),
        .mode224(mode224[1]), .dig_valid(dig_valid[1]), .dig_ready(dig_ready[1]),
        .digest(digest[1]), .blk_count(blk_count1), .proto_err(proto_err[1]));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (proto_err[0] === 1'b1) perr[0] <= perr[0] + 1;
        if (proto_err[1] === 1'b1) perr[1] <= perr[1] + 1;
    end

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] H256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
    localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_B2 = {448'h0, 32'h0, 32'h000001c0};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x};
        return xx[n +: 32];
    endfunction

    // textbook compression: full 64-word expansion, then 64 rounds, then feed-forward
    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [255:0] model_digest(input logic [511:0] blks [$], input logic m);
        logic [255:0] h;
        h = m ? H224 : H256;
        foreach (blks[i]) h = model_compress(h, blks[i]);
        if (m) h[31:0] = 32'h0;
        return h;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int get_count(input int u);
        return (u == 0) ? int'(blk_count0) : int'(blk_count1);
    endfunction

    // offer a block, wait (bounded) for acceptance; acc = cycle index of the handshake
    task automatic send_block(input int u, input logic [511:0] d, input logic f, input logic l,
                              input logic m, output int acc);
        int n;
        blk_data[u] = d; blk_first[u] = f; blk_last[u] = l; mode224[u] = m; blk_valid[u] = 1'b1;
        n = 0;
        while (blk_ready[u] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (blk_ready[u] !== 1'b1) begin
            total++; bad++;
            $display("FAIL send_block_u%0d: blk_ready=%b required=1 within 400 cycles", u, blk_ready[u]);
        end
        @(negedge clk);
        blk_valid[u] = 1'b0;
        blk_data[u]  = rand_block();
        blk_first[u] = 1'($urandom);
        blk_last[u]  = 1'($urandom);
        mode224[u]   = 1'($urandom);
    endtask

    task automatic wait_dig(input int u, input int acc, input int lat, input string nm,
                            output logic [255:0] dg);
        int n;
        n = 0;
        while (dig_valid[u] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (dig_valid[u] !== 1'b1) begin
            bad++;
            $display("FAIL %s_dig_valid: got=%b required=1 within 400 cycles", nm, dig_valid[u]);
        end else if (cyc - acc != lat) begin
            bad++;
            $display("FAIL %s_latency: got=%0d required=%0d", nm, cyc - acc, lat);
        end
        dg = digest[u];
    endtask

    // send a whole message; hold = cycles dig_ready stays low after dig_valid (0 = already high)
    task automatic run_msg(input int u, input logic [511:0] blks [$], input logic m, input int hold,
                           input string nm, output logic [255:0] dg, output int gap);
        int acc, acc_prev, lat;
        lat = (u == 0) ? 66 : 18;
        gap = 0;
        acc = 0;
        dig_ready[u] = (hold == 0);
        for (int i = 0; i < blks.size(); i++) begin
            acc_prev = acc;
            send_block(u, blks[i], i == 0, i == blks.size() - 1, m, acc);
            if (i > 0) gap = acc - acc_prev;
        end
        wait_dig(u, acc, lat, nm, dg);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            dig_ready[u] = 1'b1;
        end
        @(negedge clk);
        dig_ready[u] = 1'b0;
        total++;
        if (blk_ready[u] !== 1'b1 || dig_valid[u] !== 1'b0) begin
            bad++;
            $display("FAIL %s_release: blk_ready=%b dig_valid=%b required 1/0", nm, blk_ready[u], dig_valid[u]);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (blk_ready[u] !== 1'b0 || dig_valid[u] !== 1'b0 || digest[u] !== 256'h0 ||
                get_count(u) != 0 || proto_err[u] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs_u%0d: ready=%b dv=%b dig=%h cnt=%0d perr=%b required all 0",
                         u, blk_ready[u], dig_valid[u], digest[u], get_count(u), proto_err[u]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (blk_ready[u] !== 1'b1) begin
                bad++;
                $display("FAIL reset_release_ready_u%0d: got=%b required=1", u, blk_ready[u]);
            end
        end
    endtask

    task automatic test_abc();
        logic [511:0] q [$];
        logic [255:0] dg;
        int gap, p;
        p = perr[0];
        q = {ABC_BLK};
        run_msg(0, q, 1'b0, 0, "abc", dg, gap);
        total++;
        if (dg !== ABC256) begin bad++; $display("FAIL abc_digest: got=%h required=%h", dg, ABC256); end
        total++;
        if (blk_count0 !== 16'd1) begin bad++; $display("FAIL abc_count: got=%0d required=1", blk_count0); end
        total++;
        if (perr[0] != p) begin bad++; $display("FAIL abc_proto_err: pulses=%0d required=0", perr[0] - p); end
    endtask

    task automatic test_back_to_back();
        logic [511:0] q [$];
        logic [255:0] dg;
        int gap;
        q = {TWO_B1, TWO_B2};
        run_msg(1, q, 1'b0, 0, "two_block", dg, gap);
        total++;
        if (dg !== TWO256) begin bad++; $display("FAIL two_block_digest: got=%h required=%h", dg, TWO256); end
        total++;
        if (blk_count1 !== 2'd2) begin bad++; $display("FAIL two_block_count: got=%0d required=2", blk_count1); end
        total++;
        if (gap != 18) begin bad++; $display("FAIL two_block_period: got=%0d required=18", gap); end
    endtask

    task automatic test_sha224();
        logic [511:0] q [$];
        logic [255:0] dg;
        int gap;
        q = {ABC_BLK};
        run_msg(0, q, 1'b1, 0, "sha224", dg, gap);
        total++;
        if (dg !== ABC224) begin bad++; $display("FAIL sha224_digest: got=%h required=%h", dg, ABC224); end
    endtask

    task automatic test_backpressure();
        logic [255:0] d0;
        int acc;
        logic stable;
        dig_ready[0] = 1'b0;
        send_block(0, ABC_BLK, 1'b1, 1'b1, 1'b0, acc);
        wait_dig(0, acc, 66, "bp", d0);
        blk_valid[0] = 1'b1; blk_data[0] = rand_block(); blk_first[0] = 1'b1; blk_last[0] = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dig_valid[0] !== 1'b1 || digest[0] !== d0 || blk_ready[0] !== 1'b0) stable = 1'b0;
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_hold: dv=%b ready=%b dig=%h required 1/0/%h", dig_valid[0], blk_ready[0], digest[0], d0);
        end
        total++;
        if (d0 !== ABC256) begin bad++; $display("FAIL bp_digest: got=%h required=%h", d0, ABC256); end
        dig_ready[0] = 1'b1;
        @(negedge clk);
        blk_valid[0] = 1'b0;
        dig_ready[0] = 1'b0;
        total++;
        if (blk_ready[0] !== 1'b1 || dig_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ready=%b dv=%b required 1/0", blk_ready[0], dig_valid[0]);
        end
    endtask

    task automatic test_reset_mid_round();
        logic [511:0] q [$];
        logic [255:0] dg;
        int acc, gap, p;
        send_block(0, TWO_B1, 1'b1, 1'b0, 1'b0, acc);
        repeat (20) @(negedge clk);
        apply_reset();
        p = perr[0];
        q = {ABC_BLK};
        run_msg(0, q, 1'b0, 0, "mid_reset", dg, gap);
        total++;
        if (dg !== ABC256) begin bad++; $display("FAIL mid_reset_digest: got=%h required=%h", dg, ABC256); end
        total++;
        if (perr[0] != p) begin bad++; $display("FAIL mid_reset_proto_err: pulses=%0d required=0", perr[0] - p); end
    endtask

    task automatic test_orphan();
        logic [511:0] b;
        logic [511:0] q [$];
        logic [255:0] dg;
        int acc, p;
        apply_reset();
        p = perr[0];
        b = rand_block();
        dig_ready[0] = 1'b1;
        send_block(0, b, 1'b0, 1'b1, 1'b0, acc);
        wait_dig(0, acc, 66, "orphan", dg);
        @(negedge clk);
        dig_ready[0] = 1'b0;
        q = {b};
        total++;
        if (dg !== model_digest(q, 1'b0)) begin
            bad++; $display("FAIL orphan_digest: got=%h required=%h", dg, model_digest(q, 1'b0));
        end
        total++;
        if (perr[0] - p != 1) begin bad++; $display("FAIL orphan_proto_err: pulses=%0d required=1", perr[0] - p); end
    endtask

    task automatic test_first_while_open();
        logic [511:0] b1, b2;
        logic [511:0] q [$];
        logic [255:0] dg;
        logic m2;
        int acc, p;
        b1 = rand_block(); b2 = rand_block(); m2 = 1'($urandom);
        p = perr[1];
        dig_ready[1] = 1'b1;
        send_block(1, b1, 1'b1, 1'b0, 1'($urandom), acc);
        send_block(1, b2, 1'b1, 1'b1, m2, acc);
        wait_dig(1, acc, 18, "reopen", dg);
        @(negedge clk);
        dig_ready[1] = 1'b0;
        q = {b2};
        total++;
        if (dg !== model_digest(q, m2)) begin
            bad++; $display("FAIL reopen_digest: got=%h required=%h", dg, model_digest(q, m2));
        end
        total++;
        if (perr[1] - p != 1) begin bad++; $display("FAIL reopen_proto_err: pulses=%0d required=1", perr[1] - p); end
        total++;
        if (blk_count1 !== 2'd1) begin bad++; $display("FAIL reopen_count: got=%0d required=1", blk_count1); end
    endtask

    task automatic test_saturation();
        logic [511:0] q [$];
        logic [255:0] dg;
        logic m;
        int gap;
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(rand_block());
        m = 1'($urandom);
        run_msg(1, q, m, 1, "saturate", dg, gap);
        total++;
        if (dg !== model_digest(q, m)) begin
            bad++; $display("FAIL saturate_digest: got=%h required=%h", dg, model_digest(q, m));
        end
        total++;
        if (blk_count1 !== 2'd3) begin bad++; $display("FAIL saturate_count: got=%0d required=3", blk_count1); end
    endtask

    task automatic test_random();
        logic [511:0] q [$];
        logic [255:0] dg;
        logic m;
        int u, nb, gap, p;
        for (int it = 0; it < 8; it++) begin
            u  = it % 2;
            nb = $urandom_range(1, 3);
            m  = 1'($urandom);
            q  = {};
            for (int i = 0; i < nb; i++) q.push_back(rand_block());
            p = perr[u];
            run_msg(u, q, m, $urandom_range(0, 3), "random", dg, gap);
            total++;
            if (dg !== model_digest(q, m)) begin
                bad++;
                $display("FAIL random_digest it=%0d u=%0d: got=%h required=%h", it, u, dg, model_digest(q, m));
            end
            total++;
            if (get_count(u) != nb || perr[u] != p) begin
                bad++;
                $display("FAIL random_count it=%0d u=%0d: cnt=%0d perr=%0d required cnt=%0d perr=0",
                         it, u, get_count(u), perr[u] - p, nb);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            blk_valid[u] = 1'b0; blk_data[u] = '0; blk_first[u] = 1'b0;
            blk_last[u] = 1'b0; mode224[u] = 1'b0; dig_ready[u] = 1'b0;
        end
        test_reset();
        test_abc();
        test_back_to_back();
        test_sha224();
        test_backpressure();
        test_reset_mid_round();
        test_orphan();
        test_first_while_open();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
